sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out deserializer that shifts a 1-bit stream into a BUS-wide word and presents each completed word on a valid/ready parallel port. It is the receiving counterpart of the combinational shifters and serializers in the datapath library. Bit order is selectable: MSB-first, which shifts left, or LSB-first, which shifts right. A double-buffered output lets a new word collect while the previous one waits for the consumer.

## Interface
Parameters:
- `BUS`, default 32: word width; legal values 2 to 64.
- `DIRC`, default 1: 1 = MSB-first (left shift); 0 = LSB-first (right shift).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1: rising-edge clock.
- `reset_n`  input  1: asynchronous active-low reset.
- `clear`  input  1: synchronous flush; highest priority after reset.
- `ser_in`  input  1: serial data bit.
- `ser_valid`  input  1: `ser_in` is valid this cycle.
- `ser_ready`  output  1: the block accepts a bit this cycle.
- `data_out`  output  BUS: completed word, from the holding register.
- `par_valid`  output  1: `data_out` holds an unconsumed word.
- `par_ready`  input  1: the consumer accepts `data_out` this cycle.

## Operation
- Bit accept: `ser_valid && ser_ready`.
- Word accept: `par_valid && par_ready`.
- Shift register `shreg`, BUS bits, updated on each bit accept:
  - MSB-first: `{shreg[BUS-2:0], ser_in}`.
  - LSB-first: `{ser_in, shreg[BUS-1:1]}`.
- Bit counter `bit_cnt`, width `$clog2(BUS)`, counts 0 to BUS-1.
  - Increments on each bit accept.
  - Wraps to 0 on the BUS-th bit; there is no idle state between words.
- Word complete: a bit accept while `bit_cnt == BUS-1`.
  - The next-state value of `shreg`, including the current bit, is loaded into `data_out`.
  - `par_valid` is set.
- Output FSM, states OUT_EMPTY and OUT_FULL:
  - OUT_EMPTY to OUT_FULL on word complete.
  - OUT_FULL to OUT_EMPTY on word accept with no simultaneous word complete.
  - OUT_FULL stays OUT_FULL on a simultaneous word accept and word complete; `data_out` reloads with the new word.
- `ser_ready` is combinational and low only when all of the following hold: `bit_cnt == BUS-1`, OUT_FULL, and `!par_ready`. This stalls the final bit so no word is overwritten.
- `clear`: `bit_cnt` goes to 0, `par_valid` to 0, FSM to OUT_EMPTY. `shreg` and `data_out` keep their values. Any bit or word accept in that cycle is ignored.
- Reset values: `bit_cnt` 0, `shreg` 0, `data_out` 0, `par_valid` 0, FSM OUT_EMPTY. `ser_ready` is 1 during and after reset.

## Timing
- Latency: `par_valid` and the new `data_out` appear on the clock edge that captures the final bit, i.e. visible the cycle after the final bit is offered.
- Throughput: 1 bit per cycle, sustained without bubbles, when `par_ready` is held high.
- `data_out` is stable while `par_valid && !par_ready`.
- `par_valid` stays high until a word accept; no word is dropped or duplicated.
- Reset asserted mid-word: state returns to reset values immediately, without waiting for a clock edge. Collection restarts at bit 0 after `reset_n` deasserts.
- `ser_valid` low mid-word: the block holds `bit_cnt` and `shreg`, with no timeout.
- `ser_ready` has no combinational path from `ser_valid`; its only combinational input is `par_ready`.

## Structure
- Shared package `basic_blocks_pkg`:
  - `typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} dirc_e`.
  - `typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e`.
  - A `$clog2`-based width constant function.
- Sub-module `mod_counter` (parameters `MOD`; ports `clk`, `reset_n`, `clear`, `en`, `count`, `last`) instantiated for `bit_cnt`. Everything else stays inline.

## Test plan
- MSB-first, BUS=8: bits 1,0,1,1,0,0,1,0 on consecutive cycles with `par_ready`=1 -> `data_out`=8'hB2, `par_valid` high for exactly one cycle.
- LSB-first, BUS=8: same bit sequence -> `data_out`=8'h4D.
- Back-pressure, BUS=8: `par_ready`=0, stream 16 bits (8'hA5 then 8'h3C) -> `ser_ready` low when offered bit 16. Raise `par_ready` -> 8'hA5 accepted, then 8'h3C presented. No bit is lost.
- Continuous stream, BUS=8, `par_ready`=1: 32 bits -> 4 words, no `ser_ready` deassertion, word accept and word complete coincide cleanly.
- Mid-word `clear` after 5 bits, then 8 new bits forming 8'hFF -> `data_out`=8'hFF with no residue from the earlier bits, and `par_valid` 0 until the new word completes.
- Assert `reset_n`=0 asynchronously mid-word and while `par_valid`=1 -> `par_valid`, `data_out` and `bit_cnt` clear without a clock edge; a fresh word after release completes correctly.

Source files
------------

// File: rtl/basic_blocks_pkg.sv
// Shared types and helpers for the basic datapath blocks.
package basic_blocks_pkg;

   typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} dirc_e;

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a terminal-count flag.
module mod_counter
   import basic_blocks_pkg::*;
#(
   parameter int MOD = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   en,
   output logic [cnt_w(MOD)-1:0]  count,
   output logic                   last
);

   localparam int W = cnt_w(MOD);

   assign last = (count == W'(MOD - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word holding register
// on a valid/ready output port; bit order chosen by DIRC.
module sipo_deserializer
   import basic_blocks_pkg::*;
#(
   parameter int BUS  = 32,
   parameter int DIRC = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clear,
   input  logic           ser_in,
   input  logic           ser_valid,
   output logic           ser_ready,
   output logic [BUS-1:0] data_out,
   output logic           par_valid,
   input  logic           par_ready
);

   localparam int    CW  = cnt_w(BUS);
   localparam dirc_e DIR = (DIRC != 0) ? MSB_FIRST : LSB_FIRST;

   logic [CW-1:0]  bit_cnt;
   logic           cnt_last;
   logic [BUS-1:0] shreg;
   logic [BUS-1:0] shreg_nxt;
   logic           bit_acc;
   logic           word_acc;
   logic           word_done;
   out_state_e     state;
   out_state_e     state_nxt;

   // Stall only the final bit of a word, and only when the holding
   // register is occupied and not being drained this cycle.
   assign ser_ready = !((bit_cnt == CW'(BUS - 1)) && (state == OUT_FULL) && !par_ready);
   assign bit_acc   = ser_valid && ser_ready;
   assign word_acc  = par_valid && par_ready;
   assign word_done = bit_acc && cnt_last && !clear;
   assign par_valid = (state == OUT_FULL);

   mod_counter #(
      .MOD     (BUS)
   ) u_bit_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .en      (bit_acc),
      .count   (bit_cnt),
      .last    (cnt_last)
   );

   always_comb begin
      if (DIR == MSB_FIRST) begin
         shreg_nxt = {shreg[BUS-2:0], ser_in};
      end else begin
         shreg_nxt = {ser_in, shreg[BUS-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
      end else if (bit_acc && !clear) begin
         shreg <= shreg_nxt;
      end
   end

   // Load the word including the bit being captured this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else if (word_done) begin
         data_out <= shreg_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = OUT_EMPTY;
      end else begin
         case (state)
            OUT_EMPTY: if (word_done)             state_nxt = OUT_FULL;
            OUT_FULL:  if (word_acc && !word_done) state_nxt = OUT_EMPTY;
            default:                               state_nxt = OUT_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share
// stimulus and are compared against a bit-queue reference model.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic       ser_in;
   logic       ser_valid;
   logic       par_ready;
   logic       rdy_m, rdy_l, pv_m, pv_l;
   logic [7:0] do_m, do_l;

   always #5 clk = ~clk;

   sipo_deserializer #(.BUS(8), .DIRC(1)) u_msb (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .ser_ready (rdy_m),
      .data_out  (do_m),
      .par_valid (pv_m),
      .par_ready (par_ready)
   );

   sipo_deserializer #(.BUS(8), .DIRC(0)) u_lsb (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .ser_ready (rdy_l),
      .data_out  (do_l),
      .par_valid (pv_l),
      .par_ready (par_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: bits of the word in arrival order, plus the
   // holding register contents for each bit order.
   bit       bq[$];
   bit       full;
   bit [7:0] wm, wl;

   function automatic void model_reset();
      bq.delete();
      full = 1'b0;
      wm   = 8'h00;
      wl   = 8'h00;
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit sv, input bit sb, input bit pr, input bit clr);
      bit rdy;
      ser_valid = sv;
      ser_in    = sb;
      par_ready = pr;
      clear     = clr;
      #1;
      rdy = !(bq.size() == 7 && full && !pr);
      chk("ser_ready_msb", 64'(rdy_m), 64'(rdy));
      chk("ser_ready_lsb", 64'(rdy_l), 64'(rdy));
      if (clr) begin
         bq.delete();
         full = 1'b0;
      end else begin
         if (full && pr) full = 1'b0;
         if (sv && rdy) begin
            bq.push_back(sb);
            if (bq.size() == 8) begin
               wm = 8'h00;
               for (int i = 0; i < 8; i++) begin
                  wm    = {wm[6:0], bq[i]};
                  wl[i] = bq[i];
               end
               full = 1'b1;
               bq.delete();
            end
         end
      end
      @(posedge clk);
      #1;
      chk("par_valid_msb", 64'(pv_m), 64'(full));
      chk("par_valid_lsb", 64'(pv_l), 64'(full));
      chk("data_out_msb",  64'(do_m), 64'(wm));
      chk("data_out_lsb",  64'(do_l), 64'(wl));
      @(negedge clk);
   endtask

   task automatic send_byte_msb(input bit [7:0] b, input bit pr);
      for (int i = 7; i >= 0; i--) step(1'b1, b[i], pr, 1'b0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_par_valid", 64'(pv_m | pv_l), 64'd0);
      chk("rst_data_out",  64'({do_m, do_l}), 64'd0);
      chk("rst_ser_ready", 64'(rdy_m & rdy_l), 64'd1);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      clear     = 1'b0;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      par_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_par_valid", 64'(pv_m | pv_l), 64'd0);
      chk("reset_data_out",  64'({do_m, do_l}), 64'd0);
      chk("reset_ser_ready", 64'(rdy_m & rdy_l), 64'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic word: 1,0,1,1,0,0,1,0
      send_byte_msb(8'hB2, 1'b1);
      chk("basic_msb", 64'(do_m), 64'h B2);
      chk("basic_lsb", 64'(do_l), 64'h 4D);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("basic_one_cycle", 64'(pv_m), 64'd0);

      // Back-pressure: 16 bits with consumer stalled
      send_byte_msb(8'hA5, 1'b0);
      for (int i = 7; i >= 1; i--) step(1'b1, 1'(8'h3C >> i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_stall", 64'(rdy_m), 64'd0);
      chk("bp_hold", 64'(do_m), 64'h A5);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("bp_second", 64'(do_m), 64'h 3C);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Continuous stream of four words
      send_byte_msb(8'h12, 1'b1);
      send_byte_msb(8'hEF, 1'b1);
      send_byte_msb(8'h80, 1'b1);
      send_byte_msb(8'h7E, 1'b1);
      chk("stream_last", 64'(do_m), 64'h 7E);

      // Mid-word clear
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clear_no_valid", 64'(pv_m), 64'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clear_word", 64'(do_m), 64'h FF);

      // Async reset mid-word while a word is held
      send_byte_msb(8'h5A, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      async_reset();
      send_byte_msb(8'hC3, 1'b1);
      chk("after_reset", 64'(do_m), 64'h C3);

      // Randomized phase
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 (n / 250) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                 $urandom_range(0, 59) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
